// File: rtl/sdram_rom_port.sv
// sdram_rom_port
//   Request front-end placed directly in front of the SDRAM controller.
//   Merges the ROM download byte stream and Z80 ROM fetches onto the
//   controller's edge-triggered rd/we interface, holds address and data
//   stable until ready returns, picks the addressed byte out of the 16-bit
//   read word, and keeps a one-word read cache so repeated fetches of the
//   same word complete without an SDRAM access.
//
// Ports
//   clk, reset_n        system clock (shared with the controller), async active-low reset
//   dl_wr/dl_addr/dl_data   single-cycle download write strobe, byte address, byte
//   dl_busy             a download write is pending or in flight
//   dl_overrun          sticky: dl_wr arrived while dl_busy was set
//   cpu_req/cpu_addr    level-held CPU read request and byte address
//   cpu_dout/cpu_ack    read byte (held) and one-cycle acknowledge
//   sd_addr/sd_din/sd_we/sd_rd   request lines to the controller
//   sd_dout/sd_ready    read word and ready from the controller
//   timeout_err         sticky: a request was aborted by the watchdog
module sdram_rom_port #(
    parameter int          CPU_AW   = 16,
    parameter logic [24:0] ROM_BASE = 25'h0000000,
    parameter int          TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              dl_wr,
    input  logic [24:0]       dl_addr,
    input  logic [7:0]        dl_data,
    output logic              dl_busy,
    output logic              dl_overrun,
    input  logic              cpu_req,
    input  logic [CPU_AW-1:0] cpu_addr,
    output logic [7:0]        cpu_dout,
    output logic              cpu_ack,
    output logic [24:0]       sd_addr,
    output logic [7:0]        sd_din,
    output logic              sd_we,
    output logic              sd_rd,
    input  logic [15:0]       sd_dout,
    input  logic              sd_ready,
    output logic              timeout_err
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        ST_SETTLE,
        ST_IDLE,
        ST_STROBE,
        ST_GUARD,
        ST_WAIT
    } state_t;

    state_t           state, state_nx;
    logic             is_write, is_write_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;

    logic             cache_vld, cache_vld_nx;
    logic [23:0]      cache_tag, cache_tag_nx;
    logic [15:0]      cache_data, cache_data_nx;

    logic [24:0]      pend_addr, pend_addr_nx;
    logic [7:0]       pend_data, pend_data_nx;

    logic [24:0]      sd_addr_nx;
    logic [7:0]       sd_din_nx;
    logic             sd_we_nx, sd_rd_nx;
    logic [7:0]       cpu_dout_nx;
    logic             cpu_ack_nx;
    logic             dl_busy_nx, dl_overrun_nx, timeout_err_nx;

    logic             busy_clr;
    logic             dl_take;
    logic [24:0]      cpu_a;

    function automatic logic [7:0] byte_sel(input logic [15:0] word, input logic hi);
        return hi ? word[15:8] : word[7:0];
    endfunction

    // CPU address mapped into SDRAM space; the add wraps at 2^25.
    assign cpu_a = ROM_BASE + 25'(cpu_addr);

    always_comb begin
        state_nx       = state;
        is_write_nx    = is_write;
        cnt_nx         = cnt;
        cache_vld_nx   = cache_vld;
        cache_tag_nx   = cache_tag;
        cache_data_nx  = cache_data;
        pend_addr_nx   = pend_addr;
        pend_data_nx   = pend_data;
        sd_addr_nx     = sd_addr;
        sd_din_nx      = sd_din;
        sd_we_nx       = 1'b0;
        sd_rd_nx       = 1'b0;
        cpu_dout_nx    = cpu_dout;
        cpu_ack_nx     = 1'b0;
        dl_busy_nx     = dl_busy;
        dl_overrun_nx  = dl_overrun;
        timeout_err_nx = timeout_err;
        busy_clr       = 1'b0;
        dl_take        = 1'b0;

        case (state)
            ST_SETTLE: begin
                if (sd_ready) begin
                    state_nx = ST_IDLE;
                end
            end

            ST_IDLE: begin
                // A dl_wr arriving this very cycle counts as pending so that a
                // simultaneous CPU miss cannot jump ahead of it.
                if (dl_busy || dl_wr) begin
                    sd_addr_nx  = dl_busy ? pend_addr : dl_addr;
                    sd_din_nx   = dl_busy ? pend_data : dl_data;
                    sd_we_nx    = 1'b1;
                    is_write_nx = 1'b1;
                    state_nx    = ST_STROBE;
                end else if (cpu_req) begin
                    if (cache_vld && (cache_tag == cpu_a[24:1])) begin
                        cpu_ack_nx  = 1'b1;
                        cpu_dout_nx = byte_sel(cache_data, cpu_a[0]);
                    end else begin
                        sd_addr_nx  = cpu_a;
                        sd_rd_nx    = 1'b1;
                        is_write_nx = 1'b0;
                        state_nx    = ST_STROBE;
                    end
                end
            end

            ST_STROBE: begin
                sd_we_nx = sd_we;
                sd_rd_nx = sd_rd;
                state_nx = ST_GUARD;
            end

            ST_GUARD: begin
                // Third strobe cycle; the controller has dropped ready by the
                // time WAIT starts sampling it.
                sd_we_nx = sd_we;
                sd_rd_nx = sd_rd;
                cnt_nx   = '0;
                state_nx = ST_WAIT;
            end

            ST_WAIT: begin
                if (sd_ready) begin
                    if (is_write) begin
                        busy_clr = 1'b1;
                        // Keep the cached word coherent with the byte just written.
                        if (cache_vld && (cache_tag == sd_addr[24:1])) begin
                            if (sd_addr[0]) begin
                                cache_data_nx[15:8] = sd_din;
                            end else begin
                                cache_data_nx[7:0] = sd_din;
                            end
                        end
                    end else begin
                        cache_vld_nx  = 1'b1;
                        cache_tag_nx  = sd_addr[24:1];
                        cache_data_nx = sd_dout;
                        cpu_dout_nx   = byte_sel(sd_dout, sd_addr[0]);
                        cpu_ack_nx    = 1'b1;
                    end
                    state_nx = ST_IDLE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    // Abort: the write is lost and the cache can no longer be trusted.
                    timeout_err_nx = 1'b1;
                    cache_vld_nx   = 1'b0;
                    busy_clr       = is_write;
                    state_nx       = ST_SETTLE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end

            default: begin
                state_nx = ST_SETTLE;
            end
        endcase

        // Download capture; a slot freed this cycle may be refilled at once.
        dl_take = dl_wr && (!dl_busy || busy_clr);
        if (dl_take) begin
            pend_addr_nx = dl_addr;
            pend_data_nx = dl_data;
            dl_busy_nx   = 1'b1;
        end else if (busy_clr) begin
            dl_busy_nx   = 1'b0;
        end
        if (dl_wr && !dl_take) begin
            dl_overrun_nx = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_SETTLE;
            is_write    <= 1'b0;
            cnt         <= '0;
            cache_vld   <= 1'b0;
            sd_addr     <= '0;
            sd_din      <= '0;
            sd_we       <= 1'b0;
            sd_rd       <= 1'b0;
            cpu_dout    <= '0;
            cpu_ack     <= 1'b0;
            dl_busy     <= 1'b0;
            dl_overrun  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nx;
            is_write    <= is_write_nx;
            cnt         <= cnt_nx;
            cache_vld   <= cache_vld_nx;
            sd_addr     <= sd_addr_nx;
            sd_din      <= sd_din_nx;
            sd_we       <= sd_we_nx;
            sd_rd       <= sd_rd_nx;
            cpu_dout    <= cpu_dout_nx;
            cpu_ack     <= cpu_ack_nx;
            dl_busy     <= dl_busy_nx;
            dl_overrun  <= dl_overrun_nx;
            timeout_err <= timeout_err_nx;
        end
    end

    // Payload registers are only meaningful under their valid/busy flags.
    always_ff @(posedge clk) begin
        cache_tag  <= cache_tag_nx;
        cache_data <= cache_data_nx;
        pend_addr  <= pend_addr_nx;
        pend_data  <= pend_data_nx;
    end

endmodule

// File: tb/tb_sdram_rom_port.sv
// tb_sdram_rom_port
//   Randomized bench for sdram_rom_port with a behavioural SDRAM controller,
//   a byte-addressed reference memory, and a scoreboard of expected CPU bytes
//   and expected SDRAM accesses consumed by independent monitors.
module tb_sdram_rom_port;

    localparam logic [24:0] ROM_BASE = 25'h0010000;
    localparam int          TIMEOUT  = 20;

    typedef struct {
        bit we;
        int addr;
        int din;
    } acc_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        dl_wr;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data;
    logic        dl_busy;
    logic        dl_overrun;
    logic        cpu_req;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_ack;
    logic [24:0] sd_addr;
    logic [7:0]  sd_din;
    logic        sd_we;
    logic        sd_rd;
    logic [15:0] sd_dout;
    logic        sd_ready;
    logic        timeout_err;

    int        checks   = 0;
    int        failures = 0;
    int        exp_q[$];
    acc_t      sd_exp[$];
    bit [7:0]  ref_mem[int];
    bit [7:0]  ctl_mem[int];
    int        cache_word = -1;
    int        n_acc = 0;
    int        cur_lat = 8;
    bit        hang = 1'b0;

    always #5 clk = ~clk;

    sdram_rom_port #(
        .CPU_AW   (16),
        .ROM_BASE (ROM_BASE),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .dl_wr       (dl_wr),
        .dl_addr     (dl_addr),
        .dl_data     (dl_data),
        .dl_busy     (dl_busy),
        .dl_overrun  (dl_overrun),
        .cpu_req     (cpu_req),
        .cpu_addr    (cpu_addr),
        .cpu_dout    (cpu_dout),
        .cpu_ack     (cpu_ack),
        .sd_addr     (sd_addr),
        .sd_din      (sd_din),
        .sd_we       (sd_we),
        .sd_rd       (sd_rd),
        .sd_dout     (sd_dout),
        .sd_ready    (sd_ready),
        .timeout_err (timeout_err)
    );

    function automatic bit [7:0] init_byte(input int a);
        return 8'(a ^ (a >> 8) ^ 8'h3C);
    endfunction

    function automatic bit [7:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    function automatic bit [7:0] ctl_rd(input int a);
        return ctl_mem.exists(a) ? ctl_mem[a] : init_byte(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every ack must match the oldest expected byte.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (cpu_ack) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 32'(cpu_ack), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("cpu_dout", 32'(cpu_dout), 32'(e));
                end
            end
        end
    end

    // Behavioural SDRAM controller: edge-triggered rd/we, ready low while busy.
    initial begin
        int       lat;
        bit       busy;
        int       stb_len;
        bit       prev_stb;
        bit       stb;
        bit       edge_now;
        int       c_addr;
        bit       c_we;
        bit [7:0] c_din;
        acc_t     e;
        sd_ready = 1'b0;
        sd_dout  = 16'h0;
        busy     = 1'b0;
        stb_len  = 0;
        prev_stb = 1'b0;
        lat      = 0;
        c_addr   = 0;
        c_we     = 1'b0;
        c_din    = 8'h0;
        repeat (105) @(negedge clk);
        sd_ready = 1'b1;
        forever begin
            @(negedge clk);
            stb      = sd_rd | sd_we;
            edge_now = stb && !prev_stb;
            if (edge_now) begin
                n_acc++;
                check("strobe_excl", 32'(sd_rd & sd_we), 32'd0);
                if (sd_exp.size() == 0) begin
                    check("unexpected_access", 32'(stb), 32'd0);
                end else begin
                    e = sd_exp.pop_front();
                    check("acc_we", 32'(sd_we), 32'(e.we));
                    check("acc_addr", 32'(sd_addr), e.addr);
                    if (e.we) check("acc_din", 32'(sd_din), e.din);
                end
                if (sd_rd) check("rd_after_dl_done", 32'(dl_busy), 32'd0);
                c_addr   = int'(sd_addr);
                c_we     = sd_we;
                c_din    = sd_din;
                busy     = 1'b1;
                lat      = cur_lat;
                sd_ready = 1'b0;
                stb_len  = 0;
            end
            if (stb) stb_len++;
            if (!stb && prev_stb) check("strobe_width", 32'(stb_len), 32'd3);
            if (busy && !hang && !edge_now) begin
                lat--;
                if (lat == 0) begin
                    check("addr_hold", 32'(sd_addr), c_addr);
                    if (c_we) begin
                        check("din_hold", 32'(sd_din), 32'(c_din));
                        ctl_mem[c_addr] = c_din;
                    end else begin
                        sd_dout = {ctl_rd(c_addr | 1), ctl_rd(c_addr & ~1)};
                    end
                    sd_ready = 1'b1;
                    busy     = 1'b0;
                end
            end
            prev_stb = stb;
        end
    end

    task automatic cpu_read(input logic [15:0] addr, input bit expect_to);
        int a;
        int w;
        bit hit;
        int acc0;
        int cyc;
        bit got;
        a    = (int'(ROM_BASE) + int'(addr)) & 32'h01FF_FFFF;
        w    = a >> 1;
        hit  = (w == cache_word) && !expect_to;
        if (!expect_to) exp_q.push_back(int'(ref_rd(a)));
        if (!hit) sd_exp.push_back('{we: 1'b0, addr: a, din: 0});
        cache_word = expect_to ? -1 : w;
        acc0 = n_acc;
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_addr = addr;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 400) begin
            @(negedge clk);
            cyc++;
            got = expect_to ? timeout_err : cpu_ack;
        end
        cpu_req = 1'b0;
        check(expect_to ? "timeout_seen" : "read_done", 32'(got), 32'd1);
        if (expect_to) begin
            check("timeout_cycles", 32'(cyc), 32'(3 + TIMEOUT));
            check("timeout_access", 32'(n_acc), 32'(acc0 + 1));
        end else if (hit) begin
            check("hit_latency", 32'(cyc), 32'd1);
            check("hit_no_access", 32'(n_acc), 32'(acc0));
        end else begin
            check("miss_latency", 32'(cyc), 32'(cur_lat + 2));
            check("miss_access", 32'(n_acc), 32'(acc0 + 1));
        end
    endtask

    task automatic dl_write(input int addr, input bit [7:0] d);
        int cyc;
        sd_exp.push_back('{we: 1'b1, addr: addr, din: int'(d)});
        ref_mem[addr] = d;
        @(negedge clk);
        dl_wr   = 1'b1;
        dl_addr = 25'(addr);
        dl_data = d;
        @(negedge clk);
        dl_wr = 1'b0;
        check("dl_busy_set", 32'(dl_busy), 32'd1);
        cyc = 0;
        while (dl_busy && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check("dl_busy_clear", 32'(dl_busy), 32'd0);
    endtask

    initial begin
        int cyc;
        bit got;
        int x;
        reset_n  = 1'b0;
        dl_wr    = 1'b0;
        dl_addr  = '0;
        dl_data  = '0;
        cpu_req  = 1'b0;
        cpu_addr = '0;

        // Reset, then controller holds ready low: nothing may move.
        repeat (5) @(negedge clk);
        check("reset_ctl", 32'({cpu_ack, sd_we, sd_rd, dl_busy, dl_overrun, timeout_err}), 32'd0);
        reset_n = 1'b1;
        repeat (95) begin
            @(negedge clk);
            check("settle_ctl", 32'({cpu_dout, cpu_ack, sd_we, sd_rd, dl_busy, dl_overrun, timeout_err}), 32'd0);
            check("settle_bus", 32'({sd_addr, sd_din[6:0]}) | 32'(sd_din[7]), 32'd0);
        end
        repeat (15) @(negedge clk);

        // Directed: miss on odd byte, hit on even byte, download then hits.
        ctl_mem[32'h11234] = 8'hEF;
        ctl_mem[32'h11235] = 8'hBE;
        ref_mem[32'h11234] = 8'hEF;
        ref_mem[32'h11235] = 8'hBE;
        cur_lat = 8;
        cpu_read(16'h1235, 1'b0);
        cpu_read(16'h1234, 1'b0);
        dl_write(32'h11234, 8'h5A);
        cpu_read(16'h1234, 1'b0);
        cpu_read(16'h1235, 1'b0);

        // Simultaneous download and CPU miss, plus an overrun while busy.
        cur_lat = 6;
        x = int'(ROM_BASE) + 32'h100;
        sd_exp.push_back('{we: 1'b1, addr: x, din: 32'hC3});
        sd_exp.push_back('{we: 1'b0, addr: int'(ROM_BASE) + 32'h200, din: 0});
        ref_mem[x] = 8'hC3;
        exp_q.push_back(int'(ref_rd(int'(ROM_BASE) + 32'h200)));
        cache_word = (int'(ROM_BASE) + 32'h200) >> 1;
        @(negedge clk);
        dl_wr    = 1'b1;
        dl_addr  = 25'(x);
        dl_data  = 8'hC3;
        cpu_req  = 1'b1;
        cpu_addr = 16'h0200;
        @(negedge clk);
        dl_wr = 1'b0;
        check("sim_dl_busy", 32'(dl_busy), 32'd1);
        check("overrun_clear", 32'(dl_overrun), 32'd0);
        @(negedge clk);
        dl_wr   = 1'b1;
        dl_addr = 25'(x + 1);
        dl_data = 8'h99;
        @(negedge clk);
        dl_wr = 1'b0;
        check("overrun_set", 32'(dl_overrun), 32'd1);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 400) begin
            @(negedge clk);
            cyc++;
            got = cpu_ack;
        end
        cpu_req = 1'b0;
        check("sim_read_done", 32'(got), 32'd1);
        cpu_read(16'h0101, 1'b0);
        cpu_read(16'h0100, 1'b0);

        // Randomized mix over a small window so hits and coherency writes occur.
        for (int i = 0; i < 150; i++) begin
            cur_lat = int'($urandom_range(3, 10));
            if ($urandom_range(0, 9) < 3) begin
                dl_write(int'(ROM_BASE) + int'($urandom_range(0, 31)), 8'($urandom));
            end else begin
                cpu_read(16'($urandom_range(0, 31)), 1'b0);
            end
        end

        // Watchdog: controller never answers a read.
        cur_lat = 5;
        cpu_read(16'h0040, 1'b0);
        cpu_read(16'h0040, 1'b0);
        hang = 1'b1;
        cpu_read(16'h0300, 1'b1);
        hang = 1'b0;
        repeat (20) @(negedge clk);
        check("timeout_sticky", 32'(timeout_err), 32'd1);
        cpu_read(16'h0040, 1'b0);
        check("overrun_sticky", 32'(dl_overrun), 32'd1);
        check("timeout_sticky_end", 32'(timeout_err), 32'd1);

        repeat (5) @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("sd_exp_drained", 32'(sd_exp.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
